seg7_scan_ctrl: RTL and testbench

//  Parametrised N-digit multiplexed 7-segment driver: time-multiplexes NUM_DIGITS hex digits onto
//  one shared cathode bus. Adds per-digit blank/blink, decimal points, anti-ghost dead time and

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment scanner.
// Segment patterns are stored active-high, in {a,b,c,d,e,f,g} order.
package seg7_pkg;

  localparam int NUM_DIGITS_MAX = 8;

  // Entry 15 is listed first, so SEG7_HEX[v] returns the pattern for hex digit v.
  localparam logic [15:0][6:0] SEG7_HEX = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  function automatic logic [6:0] seg7_polarity(input logic [6:0] pattern,
                                               input logic       active_low);
    return active_low ? ~pattern : pattern;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-high 7-segment pattern, purely combinational.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] pattern
);

  assign pattern = SEG7_HEX[value];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit multiplexed 7-segment driver with blank/blink, decimal points,
// anti-ghost dead time and frame-synchronous shadow updates.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_TICKS = 262144,
  parameter int DEAD_TICKS  = 1024,
  parameter int BLINK_TICKS = 50000000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  input  logic [NUM_DIGITS-1:0]     blink_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      load,
  output logic                      busy,
  output logic                      frame_start,
  output logic [NUM_DIGITS-1:0]     anode,
  output logic [6:0]                seg,
  output logic                      dp
);

  localparam int CW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic POL_LOW = (ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = POL_LOW ? '1 : '0;
  localparam logic [6:0] SEG_OFF = POL_LOW ? 7'h7F : 7'h00;

  logic [CW-1:0]               slot_cnt;
  logic [IW-1:0]               digit_idx;
  logic [BW-1:0]               blink_cnt;
  logic                        blink_on;
  logic [NUM_DIGITS-1:0][3:0]  shadow_digits, active_digits;
  logic [NUM_DIGITS-1:0]       shadow_blank, shadow_blink, shadow_dp;
  logic [NUM_DIGITS-1:0]       active_blank, active_blink, active_dp;

  logic                        last_slot, frame_end, in_dead, cur_dark;
  logic [6:0]                  seg_pat;
  logic [NUM_DIGITS-1:0]       anode_nxt;
  logic [6:0]                  seg_nxt;
  logic                        dp_nxt;

  assign last_slot = (slot_cnt == CW'(DIGIT_TICKS - 1));
  assign frame_end = last_slot && (digit_idx == IW'(NUM_DIGITS - 1));
  assign in_dead   = (slot_cnt < CW'(DEAD_TICKS));
  assign cur_dark  = active_blank[digit_idx] | (active_blink[digit_idx] & ~blink_on);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      if (last_slot) begin
        slot_cnt  <= '0;
        digit_idx <= (digit_idx == IW'(NUM_DIGITS - 1)) ? '0 : digit_idx + IW'(1);
      end else begin
        slot_cnt  <= slot_cnt + CW'(1);
      end
      if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Commit of the old shadow and capture of a new load can share the boundary cycle;
  // the freshly loaded data then waits for the next boundary.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_digits <= '0;
      shadow_blank  <= '0;
      shadow_blink  <= '0;
      shadow_dp     <= '0;
      active_digits <= '0;
      active_blank  <= '1;
      active_blink  <= '0;
      active_dp     <= '0;
      busy          <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      frame_start <= frame_end;
      if (frame_end && busy) begin
        active_digits <= shadow_digits;
        active_blank  <= shadow_blank;
        active_blink  <= shadow_blink;
        active_dp     <= shadow_dp;
        busy          <= 1'b0;
      end
      if (load) begin
        shadow_digits <= digits_in;
        shadow_blank  <= blank_in;
        shadow_blink  <= blink_in;
        shadow_dp     <= dp_in;
        busy          <= 1'b1;
      end
    end
  end

  seg7_hex_decode u_decode (
    .value   (active_digits[digit_idx]),
    .pattern (seg_pat)
  );

  always_comb begin
    anode_nxt = ANODE_OFF;
    seg_nxt   = SEG_OFF;
    dp_nxt    = POL_LOW;
    if (!in_dead && !cur_dark) begin
      anode_nxt = POL_LOW ? ~(NUM_DIGITS'(1) << digit_idx) : (NUM_DIGITS'(1) << digit_idx);
      seg_nxt   = seg7_polarity(seg_pat, POL_LOW);
      dp_nxt    = active_dp[digit_idx] ^ POL_LOW;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anode <= ANODE_OFF;
      seg   <= SEG_OFF;
      dp    <= POL_LOW;
    end else begin
      anode <= anode_nxt;
      seg   <= seg_nxt;
      dp    <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus random loads, compared every
// cycle against a frame/slot arithmetic model of the display.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int DT = 8;
  localparam int DD = 2;
  localparam int BT = 64;
  localparam int FRAME = ND * DT;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits_in = '0;
  logic [3:0]  blank_in = '0, blink_in = '0, dp_in = '0;
  logic        load = 1'b0;
  logic        busy, frame_start, dp;
  logic [3:0]  anode;
  logic [6:0]  seg;

  always #5 clock = ~clock;

  seg7_scan_ctrl #(
    .NUM_DIGITS(ND), .DIGIT_TICKS(DT), .DEAD_TICKS(DD), .BLINK_TICKS(BT), .ACTIVE_LOW(1)
  ) dut (
    .clock(clock), .reset(reset), .digits_in(digits_in), .blank_in(blank_in),
    .blink_in(blink_in), .dp_in(dp_in), .load(load), .busy(busy),
    .frame_start(frame_start), .anode(anode), .seg(seg), .dp(dp)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex_pat(input logic [3:0] v);
    case (v)
      4'h0: return 7'h7E; 4'h1: return 7'h30; 4'h2: return 7'h6D; 4'h3: return 7'h79;
      4'h4: return 7'h33; 4'h5: return 7'h5B; 4'h6: return 7'h5F; 4'h7: return 7'h70;
      4'h8: return 7'h7F; 4'h9: return 7'h7B; 4'hA: return 7'h77; 4'hB: return 7'h1F;
      4'hC: return 7'h4E; 4'hD: return 7'h3D; 4'hE: return 7'h4F; default: return 7'h47;
    endcase
  endfunction

  // Model: n = clock edges since reset release; what is shown is what the
  // frame currently on screen holds, plus whatever is pending for the next frame.
  int          n;
  logic [15:0] a_digits, p_digits;
  logic [3:0]  a_blank, a_blink, a_dp, p_blank, p_blink, p_dp;
  bit          pending;

  task automatic model_reset();
    n = 0;
    a_digits = '0; a_blank = 4'hF; a_blink = '0; a_dp = '0;
    p_digits = '0; p_blank = '0;   p_blink = '0; p_dp = '0;
    pending = 0;
  endtask

  task automatic cycle();
    int slot, dig;
    bit lit_phase, dark, boundary;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    slot      = n % DT;
    dig       = (n / DT) % ND;
    lit_phase = ((n / BT) % 2) == 0;
    dark      = a_blank[dig] || (a_blink[dig] && !lit_phase);
    boundary  = (n % FRAME) == FRAME - 1;
    if (slot < DD || dark) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an  = ~(4'b0001 << dig);
      e_seg = ~hex_pat(a_digits[dig*4 +: 4]);
      e_dp  = ~a_dp[dig];
    end
    if (boundary && pending) begin
      a_digits = p_digits; a_blank = p_blank; a_blink = p_blink; a_dp = p_dp;
      pending = 0;
    end
    if (load) begin
      p_digits = digits_in; p_blank = blank_in; p_blink = blink_in; p_dp = dp_in;
      pending = 1;
    end
    @(posedge clock);
    #1;
    n++;
    load = 1'b0;
    check_eq("anode", 32'(anode), 32'(e_an));
    check_eq("seg", 32'(seg), 32'(e_seg));
    check_eq("dp", 32'(dp), 32'(e_dp));
    check_eq("frame_start", 32'(frame_start), 32'(boundary));
    check_eq("busy", 32'(busy), 32'(pending));
  endtask

  task automatic run(input int k);
    repeat (k) cycle();
  endtask

  task automatic wait_phase(input int p);
    while ((n % FRAME) != p) cycle();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk,
                         input logic [3:0] dpv);
    digits_in = d; blank_in = bl; blink_in = bk; dp_in = dpv;
    load = 1'b1;
    cycle();
  endtask

  task automatic check_dark_idle(input string tag);
    check_eq({tag, "_anode"}, 32'(anode), 32'hF);
    check_eq({tag, "_seg"}, 32'(seg), 32'h7F);
    check_eq({tag, "_dp"}, 32'(dp), 32'h1);
    check_eq({tag, "_busy"}, 32'(busy), 32'h0);
    check_eq({tag, "_fs"}, 32'(frame_start), 32'h0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_dark_idle("reset");
    reset = 1'b0;

    run(2 * FRAME);

    wait_phase(13);
    do_load(16'h3210, 4'b0000, 4'b0000, 4'b0100);
    run(2 * FRAME);

    wait_phase(3);
    do_load(16'hFEDC, 4'b0000, 4'b0000, 4'b0000);
    run(5);
    do_load(16'hBA98, 4'b0000, 4'b0000, 4'b1001);
    run(2 * FRAME);

    do_load(16'h4567, 4'b0000, 4'b0001, 4'b0000);
    run(5 * BT);

    do_load(16'h89AB, 4'b1010, 4'b0000, 4'b1111);
    run(3 * FRAME);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        digits_in = 16'($urandom);
        blank_in  = 4'($urandom);
        blink_in  = 4'($urandom);
        dp_in     = 4'($urandom);
        load      = 1'b1;
      end
      cycle();
    end

    // Asynchronous reset 3 cycles into the digit 2 slot with an update pending.
    wait_phase(5);
    do_load(16'h1357, 4'b0000, 4'b0000, 4'b1111);
    wait_phase(2 * DT + 3);
    reset = 1'b1;
    #1;
    check_dark_idle("midreset");
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    run(2 * FRAME + 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
